// File: rtl/pipeline_defines.sv
// Shared definitions for the MEM-stage data-side request path.
package pipeline_defines;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD,
        CANCEL
    } dcache_req_state_t;

    localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
    localparam logic [1:0] BUS_SIZE_WORD = 2'd2;

    // MEM-side cache request bundle as produced by the MEM stage.
    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } mem_cache_struct;

endpackage

// File: rtl/mem_sel_decode.sv
// Byte-lane select to bus transfer size; shared with the uncached path.
module mem_sel_decode
    import pipeline_defines::*;
(
    input  logic [3:0] i_sel,
    output logic [1:0] o_size,
    output logic       o_valid
);

    // An empty select marks a misaligned access that never reaches the bus.
    always_comb begin
        o_valid = (i_sel != 4'b0000);
        o_size  = BUS_SIZE_WORD;
        case (i_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = BUS_SIZE_BYTE;
            4'b0011, 4'b1100:                   o_size = BUS_SIZE_HALF;
            default:                            o_size = BUS_SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/mem_dcache_req_ctrl.sv
// Converts the level-held MEM cache request into one SRAM-like bus
// transaction per instruction and holds the result until the pipeline moves.
module mem_dcache_req_ctrl
    import pipeline_defines::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_ce_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [3:0]            req_sel_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic                  flush_i,
    input  logic                  advance_i,
    output logic                  addr_ok_o,
    output logic                  data_ok_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  bus_req_o,
    output logic                  bus_wr_o,
    output logic [1:0]            bus_size_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_wstrb_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_addr_ok_i,
    input  logic                  bus_data_ok_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    dcache_req_state_t     r_state;
    dcache_req_state_t     w_next;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_sel;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            w_size;
    logic                  w_sel_valid;
    logic                  w_latch_req;
    logic                  w_latch_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_next;

    mem_sel_decode u_sel_decode (
        .i_sel   (req_sel_i),
        .o_size  (w_size),
        .o_valid (w_sel_valid)
    );

    always_comb begin
        w_next        = r_state;
        w_latch_req   = 1'b0;
        w_latch_rdata = 1'b0;
        w_rdata_next  = '0;
        bus_req_o     = 1'b0;
        addr_ok_o     = 1'b0;
        data_ok_o     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_ce_i && !flush_i) begin
                    if (w_sel_valid) begin
                        w_latch_req = 1'b1;
                        w_next      = ADDR;
                    end else begin
                        w_latch_rdata = 1'b1;
                        w_next        = HOLD;
                    end
                end
            end
            ADDR: begin
                // Request stays up for the whole cycle; a flush withdraws it next cycle.
                bus_req_o = 1'b1;
                addr_ok_o = bus_addr_ok_i;
                if (bus_addr_ok_i) begin
                    w_next = flush_i ? CANCEL : DATA;
                end else if (flush_i) begin
                    w_next = IDLE;
                end
            end
            DATA: begin
                if (bus_data_ok_i) begin
                    if (flush_i) begin
                        w_next = IDLE;
                    end else begin
                        w_latch_rdata = 1'b1;
                        w_rdata_next  = r_we ? '0 : bus_rdata_i;
                        w_next        = HOLD;
                    end
                end else if (flush_i) begin
                    w_next = CANCEL;
                end
            end
            HOLD: begin
                data_ok_o = 1'b1;
                if (advance_i || flush_i) begin
                    w_next = IDLE;
                end
            end
            CANCEL: begin
                if (bus_data_ok_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_size  <= BUS_SIZE_BYTE;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch_req) begin
                r_we    <= req_we_i;
                r_addr  <= req_addr_i;
                r_sel   <= req_sel_i;
                r_size  <= w_size;
                r_wdata <= req_wdata_i;
            end
            if (w_latch_rdata) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    assign rdata_o     = r_rdata;
    assign bus_wr_o    = r_we;
    assign bus_size_o  = r_size;
    assign bus_addr_o  = r_addr;
    assign bus_wstrb_o = r_we ? r_sel : 4'b0000;
    assign bus_wdata_o = r_wdata;

endmodule

// File: doc/mem_dcache_req_ctrl.md
Name: mem_dcache_req_ctrl

Overview:
- Sits directly downstream of the MEM stage, between its cache-request outputs (ce/we/addr/sel/data) and the data-side SRAM-like bus to the dcache/AXI bridge.
- Turns the level-held MEM request into exactly one bus transaction per instruction.
- Returns addr_ok/data_ok/rdata to MEM and holds data_ok and rdata until the pipeline advances.
- Drains already-accepted bus transactions silently after a flush.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; sel/wstrb width is DATA_WIDTH/8.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- req_ce_i  input  1  MEM request valid; held high while MEM stalls.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_sel_i  input  4  byte lane select.
- req_wdata_i  input  DATA_WIDTH  lane-replicated store data.
- flush_i  input  1  pipeline flush (exception/ertn/refetch).
- advance_i  input  1  MEM→WB register updates this cycle.
- addr_ok_o  output  1  to MEM; bus accepted the current request.
- data_ok_o  output  1  to MEM; access complete.
- rdata_o  output  DATA_WIDTH  load data, valid while data_ok_o=1.
- bus_req_o  output  1  bus request.
- bus_wr_o  output  1  bus write.
- bus_size_o  output  2  0 = byte, 1 = half, 2 = word.
- bus_addr_o  output  ADDR_WIDTH  bus address.
- bus_wstrb_o  output  4  write strobe; 0 for loads.
- bus_wdata_o  output  DATA_WIDTH  write data.
- bus_addr_ok_i  input  1  bus accepted the request.
- bus_data_ok_i  input  1  response valid.
- bus_rdata_i  input  DATA_WIDTH  response data.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including rdata_o and the latched request.
- States: IDLE, ADDR, DATA, HOLD, CANCEL.
- IDLE:
  - req_ce_i & !flush_i & sel≠0: latch we/addr/sel/wdata; → ADDR.
  - req_ce_i & sel==0 (misaligned half from MEM): no bus access; rdata latch=0; → HOLD.
- ADDR:
  - bus_req_o=1; bus_* driven from latched regs, so they are stable while bus_req_o=1.
  - addr_ok_o=bus_addr_ok_i, combinational.
  - bus_addr_ok_i: → DATA, or → CANCEL if flush_i the same cycle.
  - flush_i & !bus_addr_ok_i: drop bus_req_o; → IDLE (request withdrawal is legal on this bus).
- DATA:
  - bus_data_ok_i: latch bus_rdata_i (0 for stores); → HOLD, or → IDLE if flush_i the same cycle (data discarded).
  - flush_i without bus_data_ok_i: → CANCEL.
- HOLD:
  - data_ok_o=1; rdata_o=latch.
  - advance_i or flush_i: → IDLE.
  - req_ce_i in HOLD is ignored; it belongs to the same instruction.
- CANCEL: data_ok_o=0; no new request accepted; bus_data_ok_i → IDLE.
- Exactly one bus_req handshake per accepted request. No second transaction until the previous bus_data_ok_i has been seen.
- Size decode from sel:
  - 0001/0010/0100/1000 → size 0.
  - 0011/1100 → size 1.
  - 1111 → size 2.
  - Any other nonzero sel → size 2.
- bus_wstrb_o=sel if we, else 0.
- Minimum latency, req_ce_i to data_ok_o:
  - req_ce_i at cycle 0; bus_req_o at cycle 1 with bus_addr_ok_i same cycle.
  - bus_data_ok_i at cycle 2; data_ok_o at cycle 3.
  - Back-to-back: the next request is accepted in the cycle after advance_i.
- flush_i in IDLE has no effect, and a same-cycle req_ce_i is ignored.

Decomposition:
- Shared package pipeline_defines:
  - dcache_req_state_t enum (IDLE, ADDR, DATA, HOLD, CANCEL).
  - BUS_SIZE_BYTE/HALF/WORD constants.
  - Reuse mem_cache_struct for the MEM-side request in the parent hookup.
- One sub-module, mem_sel_decode: combinational sel → {size, valid} decoder, reusable by the uncached path.

Test Plan:
- Load word: ce=1, we=0, addr=0x1C000010, sel=1111; bus_addr_ok in cycle 1; bus_data_ok with rdata 0xDEADBEEF in cycle 2 → data_ok_o=1 with rdata_o=0xDEADBEEF in cycle 3, held until advance_i; exactly one bus_req handshake.
- Store byte: addr=0x...03, sel=1000, wdata=0x55555555 → bus_size=0, bus_wstrb=1000, bus_wr=1; data_ok_o held through 3 stall cycles; no re-issue.
- Bus backpressure: bus_addr_ok low for 4 cycles → bus_req_o and bus_addr_o stable all 4 cycles; addr_ok_o=0 until accepted.
- Flush in DATA: flush_i one cycle after the handshake; response 2 cycles later → no data_ok_o; a new req_ce_i during CANCEL is not issued until the response arrives, then it is issued from IDLE.
- Flush in ADDR without accept → bus_req_o drops next cycle; state IDLE; no later bus_data_ok expected.
- Async reset asserted in DATA → all outputs 0 immediately; after release, state IDLE and a fresh load completes normally.
